// File: rtl/axis_packet_mux.sv
// axis_packet_mux: forwards one whole AXI-Stream packet from the arbiter-granted
// input to a registered output, then re-arbitrates.
module axis_packet_mux #(
   parameter int N      = 4,
   parameter int DATA_W = 8,
   parameter int CNT_W  = 16
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [N*DATA_W-1:0] s_tdata,
   input  logic [N-1:0]        s_tvalid,
   input  logic [N-1:0]        s_tlast,
   output logic [N-1:0]        s_tready,
   output logic [DATA_W-1:0]   m_tdata,
   output logic                m_tvalid,
   output logic                m_tlast,
   input  logic                m_tready,
   output logic [N-1:0]        arb_req,
   output logic                arb_enable,
   input  logic [N-1:0]        arb_grant,
   output logic [CNT_W-1:0]    pkt_count
);
   typedef enum logic [1:0] {IDLE, GRANT, PASS} state_t;
   state_t state;
   logic [N-1:0] sel;
   logic [DATA_W-1:0] sel_data;
   logic sel_valid, sel_last, room, accept;
   always_comb begin
      sel_data  = '0;
      sel_valid = 1'b0;
      sel_last  = 1'b0;
      for (int i = 0; i < N; i++) begin
         sel_data  = sel_data | (sel[i] ? s_tdata[i*DATA_W +: DATA_W] : '0);
         sel_valid = sel_valid | (sel[i] & s_tvalid[i]);
         sel_last  = sel_last | (sel[i] & s_tlast[i]);
      end
   end
   assign room       = !m_tvalid || m_tready;
   assign accept     = state == PASS && sel_valid && room;
   assign s_tready   = (state == PASS && !rst && room) ? sel : '0;
   assign arb_req    = s_tvalid;
   assign arb_enable = state == IDLE && !rst && |s_tvalid;
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         sel       <= '0;
         m_tdata   <= '0;
         m_tvalid  <= 1'b0;
         m_tlast   <= 1'b0;
         pkt_count <= '0;
      end else begin
         if (m_tvalid && m_tready && m_tlast) pkt_count <= pkt_count + 1'b1;
         if (accept) begin
            m_tdata  <= sel_data;
            m_tlast  <= sel_last;
            m_tvalid <= 1'b1;
         end else if (m_tready) begin
            m_tvalid <= 1'b0;
         end
         case (state)
            IDLE: if (|s_tvalid) state <= GRANT;
            GRANT: begin
               state <= |arb_grant ? PASS : IDLE;
               // an illegal multi-hot grant degrades to its lowest set bit
               if (|arb_grant) sel <= arb_grant & (~arb_grant + 1'b1);
            end
            PASS: if (accept && sel_last) state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end
   assert property (@(posedge clk) disable iff (rst) state == GRANT |-> $onehot0(arb_grant));
endmodule

// File: tb/tb_axis_packet_mux.sv
// tb_axis_packet_mux: cycle table for single-input and backpressure traffic, plus
// queue-driven sequences for fairness, repeat-grant suppression and mid-packet reset.
module tb_axis_packet_mux;
   localparam int N = 4, DW = 8, CW = 16;
   logic clk = 1'b0, rst = 1'b1;
   logic [N*DW-1:0] s_tdata = '0;
   logic [N-1:0] s_tvalid = '1, s_tlast = '0, s_tready, arb_req, arb_grant;
   logic [DW-1:0] m_tdata;
   logic m_tvalid, m_tlast, m_tready = 1'b1, arb_enable;
   logic [CW-1:0] pkt_count;
   int checks = 0, errors = 0, cyc = 0;
   logic [8:0] q [N][$];
   logic [8:0] olog[$];
   int ocyc[$];

   axis_packet_mux #(.N(N), .DATA_W(DW), .CNT_W(CW)) dut (
      .clk(clk), .rst(rst), .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tlast(s_tlast),
      .s_tready(s_tready), .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tlast(m_tlast),
      .m_tready(m_tready), .arb_req(arb_req), .arb_enable(arb_enable),
      .arb_grant(arb_grant), .pkt_count(pkt_count));

   always #5 clk = ~clk;

   // round-robin arbiter model; a repeat grant to the previous winner is refused once
   int last_m;
   logic has_m, sup_m;
   function automatic int rr_pick(logic [N-1:0] req, int last);
      int pick = -1;
      for (int k = 1; k <= N; k++) if (pick < 0 && req[(last + k) % N]) pick = (last + k) % N;
      return pick;
   endfunction
   always @(posedge clk) begin
      if (rst) begin
         arb_grant <= '0; last_m <= N - 1; has_m <= 1'b0; sup_m <= 1'b0;
      end else if (arb_enable) begin
         if (rr_pick(arb_req, last_m) < 0) arb_grant <= '0;
         else if (has_m && rr_pick(arb_req, last_m) == last_m && !sup_m) begin
            arb_grant <= '0; sup_m <= 1'b1;
         end else begin
            arb_grant <= '0;
            arb_grant[rr_pick(arb_req, last_m)] <= 1'b1;
            last_m <= rr_pick(arb_req, last_m); has_m <= 1'b1; sup_m <= 1'b0;
         end
      end
   end

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic run(input int n);
      for (int c = 0; c < n; c++) begin
         for (int p = 0; p < N; p++) begin
            s_tvalid[p] = q[p].size() != 0;
            {s_tlast[p], s_tdata[p*DW +: DW]} = 9'd0;
            if (q[p].size() != 0) {s_tlast[p], s_tdata[p*DW +: DW]} = q[p][0];
         end
         @(negedge clk);
         if (m_tvalid && m_tready) begin
            olog.push_back({m_tlast, m_tdata});
            ocyc.push_back(cyc);
         end
         for (int p = 0; p < N; p++) if (s_tvalid[p] && s_tready[p]) void'(q[p].pop_front());
         @(posedge clk); #1;
         cyc++;
      end
   endtask

   task automatic do_reset();
      rst = 1'b1; s_tvalid = '0; s_tlast = '0; s_tdata = '0; m_tready = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      olog.delete(); ocyc.delete(); cyc = 0;
   endtask

   typedef struct {int p, v, d, l, mr, sr, en, mv, md, ml, pc;} vec_t;
   vec_t tbl[$];

   initial begin
      // port idx, valid, data, last, m_tready | s_tready, arb_enable, m_tvalid, m_tdata, m_tlast, pkt_count
      tbl.push_back('{2, 1, 'h10, 0, 1,  0, 1, 0, 0,    0, 0});
      tbl.push_back('{2, 1, 'h10, 0, 1,  0, 0, 0, 0,    0, 0});
      tbl.push_back('{2, 1, 'h10, 0, 1,  4, 0, 0, 0,    0, 0});
      tbl.push_back('{2, 1, 'h11, 0, 1,  4, 0, 1, 'h10, 0, 0});
      tbl.push_back('{2, 1, 'h12, 0, 1,  4, 0, 1, 'h11, 0, 0});
      tbl.push_back('{2, 1, 'h13, 1, 1,  4, 0, 1, 'h12, 0, 0});
      tbl.push_back('{2, 0, 0,    0, 1,  0, 0, 1, 'h13, 1, 0});
      tbl.push_back('{2, 0, 0,    0, 1,  0, 0, 0, 0,    0, 1});
      tbl.push_back('{0, 1, 'h20, 0, 1,  0, 1, 0, 0,    0, 1});
      tbl.push_back('{0, 1, 'h20, 0, 0,  0, 0, 0, 0,    0, 1});
      tbl.push_back('{0, 1, 'h20, 0, 0,  1, 0, 0, 0,    0, 1});
      tbl.push_back('{0, 1, 'h21, 0, 1,  1, 0, 1, 'h20, 0, 1});
      tbl.push_back('{0, 1, 'h22, 1, 0,  0, 0, 1, 'h21, 0, 1});
      tbl.push_back('{0, 1, 'h22, 1, 0,  0, 0, 1, 'h21, 0, 1});
      tbl.push_back('{0, 1, 'h22, 1, 1,  1, 0, 1, 'h21, 0, 1});
      tbl.push_back('{0, 0, 0,    0, 0,  0, 0, 1, 'h22, 1, 1});
      tbl.push_back('{0, 0, 0,    0, 1,  0, 0, 1, 'h22, 1, 1});
      tbl.push_back('{0, 0, 0,    0, 1,  0, 0, 0, 0,    0, 2});

      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("rst_s_tready", int'(s_tready), 0);
         chk("rst_arb_enable", int'(arb_enable), 0);
         chk("rst_m_tvalid", int'(m_tvalid), 0);
         chk("rst_pkt_count", int'(pkt_count), 0);
      end
      @(posedge clk); #1;
      rst = 1'b0; s_tvalid = '0;

      foreach (tbl[i]) begin
         s_tvalid = '0; s_tlast = '0; s_tdata = '0;
         s_tvalid[tbl[i].p] = tbl[i].v[0];
         s_tlast[tbl[i].p] = tbl[i].l[0];
         s_tdata[tbl[i].p*DW +: DW] = tbl[i].d[DW-1:0];
         m_tready = tbl[i].mr[0];
         @(negedge clk);
         chk($sformatf("row%0d_s_tready", i), int'(s_tready), tbl[i].sr);
         chk($sformatf("row%0d_arb_enable", i), int'(arb_enable), tbl[i].en);
         chk($sformatf("row%0d_m_tvalid", i), int'(m_tvalid), tbl[i].mv);
         chk($sformatf("row%0d_pkt_count", i), int'(pkt_count), tbl[i].pc);
         if (tbl[i].mv != 0) begin
            chk($sformatf("row%0d_m_tdata", i), int'(m_tdata), tbl[i].md);
            chk($sformatf("row%0d_m_tlast", i), int'(m_tlast), tbl[i].ml);
         end
         @(posedge clk); #1;
      end

      // fairness: every port holds two 2-beat packets; data = port*16 + pkt*2 + beat
      do_reset();
      for (int p = 0; p < N; p++)
         for (int j = 0; j < 4; j++) q[p].push_back({j[0] == 1'b1, 8'(p*16 + j)});
      run(45);
      chk("fair_beats", olog.size(), 16);
      for (int j = 0; j < 16 && j < olog.size(); j++)
         chk($sformatf("fair_beat%0d", j), int'(olog[j]),
             int'({j % 2 == 1, 8'(((j/2) % 4)*16 + ((j/2)/4)*2 + j % 2)}));
      chk("fair_pkt_count", int'(pkt_count), 8);

      // repeat requester: second grant to port 1 is refused once
      do_reset();
      q[1].push_back({1'b1, 8'h50});
      q[1].push_back({1'b1, 8'h51});
      run(14);
      chk("rep_beats", olog.size(), 2);
      if (olog.size() == 2) begin
         chk("rep_first", int'(olog[0]), 'h150);
         chk("rep_second", int'(olog[1]), 'h151);
         chk("rep_latency", ocyc[0], 3);
         chk("rep_gap", ocyc[1] - ocyc[0], 5);
      end
      chk("rep_pkt_count", int'(pkt_count), 2);

      // mid-packet reset after two beats of a 5-beat packet on port 3
      olog.delete(); ocyc.delete(); cyc = 0;
      for (int j = 0; j < 5; j++) q[3].push_back({j == 4, 8'(8'h30 + j)});
      run(4);
      chk("mid_pre_m_tdata", int'(m_tdata), 'h31);
      rst = 1'b1;
      @(negedge clk);
      chk("mid_rst_s_tready", int'(s_tready), 0);
      chk("mid_rst_arb_enable", int'(arb_enable), 0);
      @(posedge clk); #1;
      chk("mid_m_tvalid", int'(m_tvalid), 0);
      chk("mid_m_tdata", int'(m_tdata), 0);
      chk("mid_m_tlast", int'(m_tlast), 0);
      chk("mid_pkt_count", int'(pkt_count), 0);
      rst = 1'b0;
      q[3].delete(); olog.delete(); ocyc.delete(); cyc = 0;
      for (int j = 0; j < 5; j++) q[3].push_back({j == 4, 8'(8'h40 + j)});
      run(14);
      chk("resend_beats", olog.size(), 5);
      for (int j = 0; j < 5 && j < olog.size(); j++)
         chk($sformatf("resend_beat%0d", j), int'(olog[j]), int'({j == 4, 8'(8'h40 + j)}));
      chk("resend_pkt_count", int'(pkt_count), 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/axis_packet_mux.md
# axis_packet_mux

Packet-level AXI-Stream multiplexer for the AXI-Stream switch. It sits directly downstream of the round-robin arbiter. It presents the N input `tvalid` lines to the arbiter as requests and pulses the arbiter's enable. It then latches the one-hot grant and forwards exactly one complete packet, up to and including `tlast`, from the granted input to a registered output before it re-arbitrates.

## Interface
Parameters:
- `N`, 4: number of input streams (≥2; equals the arbiter's N).
- `DATA_W`, 8: tdata width in bits.
- `CNT_W`, 16: width of the completed-packet counter.

Ports:
- `clk`  in  1  clock; all logic on the rising edge.
- `rst`  in  1  reset, synchronous and active-high. The arbiter instance is reset from the same source (`resn = ~rst`).
- `s_tdata`  in  N*DATA_W  input data; lane i occupies bits [i*DATA_W +: DATA_W].
- `s_tvalid`  in  N  per-input valid.
- `s_tlast`  in  N  per-input end of packet.
- `s_tready`  out  N  per-input ready.
- `m_tdata`  out  DATA_W  output data, registered.
- `m_tvalid`  out  1  output valid, registered.
- `m_tlast`  out  1  output last, registered.
- `m_tready`  in  1  output ready.
- `arb_req`  out  N  request vector to the arbiter; equals `s_tvalid`.
- `arb_enable`  out  1  one-cycle arbitration strobe to the arbiter.
- `arb_grant`  in  N  registered one-hot grant from the arbiter.
- `pkt_count`  out  CNT_W  number of packets completed at the output; wraps.

## Operation
- FSM states: IDLE, GRANT, PASS.
- IDLE:
  - `arb_enable = |s_tvalid`.
  - If `|s_tvalid`, go to GRANT; otherwise stay in IDLE.
- GRANT:
  - `arb_enable = 0`. The arbiter's grant was updated at the end of the IDLE cycle and is stable here.
  - If `arb_grant != 0`, latch it into `sel` (one-hot) and go to PASS.
  - If `arb_grant == 0`, go to IDLE. This happens when the arbiter suppresses a repeat grant to the same requester, and the block retries on the following cycle.
- PASS:
  - `s_tready[i] = sel[i] & (!m_tvalid | m_tready)`; all other `s_tready` bits are 0.
  - On each accepted beat (`s_tvalid[sel] & s_tready[sel]`), load `m_tdata`, `m_tlast` and `m_tvalid <= 1`.
  - An accepted beat with `s_tlast[sel] = 1` sends the FSM to IDLE at the same edge.
- Output register:
  - When `m_tvalid & m_tready` and no new beat is loaded, `m_tvalid <= 0`.
  - The register may still hold the final beat while the FSM re-arbitrates.
- `pkt_count` increments by 1 on each output handshake with `m_tlast = 1`. It wraps from 2^CNT_W-1 to 0.
- `s_tready` is 0 in IDLE and GRANT. The AXI-Stream rule (valid held until ready) guarantees that the granted requester is still valid in PASS.
- A non-one-hot `arb_grant` is a protocol violation. For the mux select, the lowest set bit wins; verification flags it with an assertion.

## Timing
- Reset values (while `rst` is high, at the next edge):
  - FSM in IDLE, `sel = 0`.
  - `m_tvalid = 0`, `m_tdata = 0`, `m_tlast = 0`, `pkt_count = 0`.
  - `s_tready = 0` and `arb_enable = 0`; both are forced low combinationally while `rst` is high.
- Startup latency with an idle output: `s_tvalid` rises in cycle t (IDLE, enable high) → GRANT in t+1 → PASS in t+2 (beat accepted) → `m_tvalid` high in t+3.
- Throughput in PASS: one beat per cycle while `m_tready = 1`.
- Inter-packet gap: `tlast` is accepted at the end of cycle k → IDLE at k+1 → GRANT at k+2 → first beat accepted at k+3. This gives 2 input-side bubble cycles.
- Repeat-grant suppression costs 2 extra cycles per retry (GRANT → IDLE → GRANT).
- A single-beat packet (`tlast` on the first beat) is legal: PASS lasts 1 cycle.
- Backpressure: with `m_tready = 0` and `m_tvalid = 1`, `s_tready[sel]` is 0 and `m_tdata`/`m_tlast` hold.
- Reset asserted mid-packet: the partial packet is abandoned and the output is cleared at the next edge. Nothing is flushed. The arbiter is reset in the same cycle.

## Test plan
- Reset: hold `rst` high for 3 cycles with all `s_tvalid = 1` → `s_tready = 0`, `arb_enable = 0`, `m_tvalid = 0`, `pkt_count = 0` throughout.
- Single input: port 2 sends a 4-beat packet (0x10..0x13, last on 0x13) with `m_tready = 1` → `m_tvalid` rises 3 cycles after `s_tvalid`; output is 0x10,0x11,0x12,0x13 with `m_tlast` only on 0x13; `pkt_count = 1`.
- Fairness: all 4 ports continuously send 2-beat packets → output packet order is port 0,1,2,3,0,1,…; no packet is interleaved with another.
- Repeat requester: only port 1 sends two back-to-back 1-beat packets → the second grant is suppressed once (GRANT sees 0 and returns to IDLE); the second packet emerges 2 cycles later than the nominal gap; `pkt_count = 2`.
- Backpressure: a 3-beat packet with `m_tready` toggling 1,0,0,1,… → no beat lost or duplicated; `m_tdata` stable while `m_tvalid & !m_tready`.
- Mid-packet reset: assert `rst` after beat 2 of a 5-beat packet, then release and resend → output register cleared; the next packet is delivered intact and `pkt_count` restarts from 0.
